// File: rtl/cpu_sequencer.sv
// Phase sequencer for the accumulator CPU: generates the one-hot fetch/exec1/exec2
// phase vector, stretches phases across the memory handshake, and handles run/step/halt.
module cpu_sequencer #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             clear,
    input  logic [3:0]       inst,
    input  logic             mem_ack,
    output logic [2:0]       state,
    output logic             phase_done,
    output logic             ir_load,
    output logic             mem_req,
    output logic             halted,
    output logic             bus_err,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC1 = 3'd2,
        S_EXEC2 = 3'd3,
        S_HALT  = 3'd4
    } fsm_t;

    // Wait counter compares against the last allowed unacknowledged cycle.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    fsm_t             fsm_r;
    fsm_t             fsm_nxt_s;
    logic [7:0]       wait_cnt_r;
    logic [CNT_W-1:0] instr_count_r;
    logic             bus_err_r;

    logic [2:0]       state_s;
    logic             mem_req_s;
    logic             phase_done_s;
    logic             halted_s;
    logic             illegal_s;
    logic             retire_s;
    logic             timeout_s;
    fsm_t             retire_nxt_s;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

    function automatic logic is_two_phase_op(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0010) || (op == 4'b0011) || (op[3:2] == 2'b11);
    endfunction

    function automatic logic is_stp_op(input logic [3:0] op);
        return (op == 4'b0111);
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op == 4'b1001) || (op == 4'b1010) || (op == 4'b1011);
    endfunction

    assign timeout_s    = mem_req_s & ~mem_ack & (wait_cnt_r == WAIT_LAST);
    assign retire_nxt_s = (step_mode | ~run) ? S_IDLE : S_FETCH;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r <= S_IDLE;
        end else begin
            fsm_r <= fsm_nxt_s;
        end
    end

    // Next-state logic; an ack always beats a timeout landing in the same cycle.
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            S_IDLE: begin
                if (run && !step_mode) begin
                    fsm_nxt_s = S_FETCH;
                end else if (step_mode && step_req) begin
                    fsm_nxt_s = S_FETCH;
                end else begin
                    fsm_nxt_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (phase_done_s) begin
                    fsm_nxt_s = S_EXEC1;
                end else if (timeout_s) begin
                    fsm_nxt_s = S_HALT;
                end else begin
                    fsm_nxt_s = S_FETCH;
                end
            end
            S_EXEC1: begin
                if (phase_done_s) begin
                    if (is_stp_op(inst)) begin
                        fsm_nxt_s = S_HALT;
                    end else if (is_two_phase_op(inst)) begin
                        fsm_nxt_s = S_EXEC2;
                    end else begin
                        fsm_nxt_s = retire_nxt_s;
                    end
                end else if (timeout_s) begin
                    fsm_nxt_s = S_HALT;
                end else begin
                    fsm_nxt_s = S_EXEC1;
                end
            end
            S_EXEC2: begin
                fsm_nxt_s = retire_nxt_s;
            end
            S_HALT: begin
                if (clear) begin
                    fsm_nxt_s = S_IDLE;
                end else begin
                    fsm_nxt_s = S_HALT;
                end
            end
            default: begin
                fsm_nxt_s = S_IDLE;
            end
        endcase
    end

    // Phase vector, handshake and strobe decode from the current FSM state.
    always_comb begin
        state_s      = 3'b000;
        mem_req_s    = 1'b0;
        phase_done_s = 1'b0;
        halted_s     = 1'b0;
        illegal_s    = 1'b0;
        retire_s     = 1'b0;
        case (fsm_r)
            S_IDLE: begin
                state_s = 3'b000;
            end
            S_FETCH: begin
                state_s      = 3'b001;
                mem_req_s    = 1'b1;
                phase_done_s = mem_ack;
            end
            S_EXEC1: begin
                state_s = 3'b010;
                if (is_mem_op(inst)) begin
                    mem_req_s    = 1'b1;
                    phase_done_s = mem_ack;
                end else begin
                    phase_done_s = 1'b1;
                end
                illegal_s = phase_done_s & is_illegal_op(inst);
                retire_s  = phase_done_s & ~is_stp_op(inst) & ~is_two_phase_op(inst);
            end
            S_EXEC2: begin
                state_s      = 3'b100;
                phase_done_s = 1'b1;
                retire_s     = 1'b1;
            end
            S_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                state_s = 3'b000;
            end
        endcase
    end

    // Unacknowledged-request counter, restarted at every phase boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 8'd0;
        end else if (phase_done_s || !mem_req_s || timeout_s) begin
            wait_cnt_r <= 8'd0;
        end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end
    end

    // Retired-instruction counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count_r <= '0;
        end else if (retire_s && !(&instr_count_r)) begin
            instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instr_count_r <= instr_count_r;
        end
    end

    // Sticky bus error: set by timeout, cleared only when clear releases HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_r <= 1'b0;
        end else if (timeout_s) begin
            bus_err_r <= 1'b1;
        end else if ((fsm_r == S_HALT) && clear) begin
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= bus_err_r;
        end
    end

    assign state       = state_s;
    assign phase_done  = phase_done_s;
    assign ir_load     = state_s[0] & phase_done_s;
    assign mem_req     = mem_req_s;
    assign halted      = halted_s;
    assign bus_err     = bus_err_r;
    assign illegal     = illegal_s;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues expected phases, a monitor
// checks each phase_done strobe; a small memory model answers requests after a delay.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        step_mode;
    logic        step_req;
    logic        clear;
    logic [3:0]  inst;
    logic        mem_ack;
    logic [2:0]  state;
    logic        phase_done;
    logic        ir_load;
    logic        mem_req;
    logic        halted;
    logic        bus_err;
    logic        illegal;
    logic [15:0] instr_count;

    cpu_sequencer #(.WAIT_MAX(15), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step_mode(step_mode),
        .step_req(step_req), .clear(clear), .inst(inst), .mem_ack(mem_ack),
        .state(state), .phase_done(phase_done), .ir_load(ir_load),
        .mem_req(mem_req), .halted(halted), .bus_err(bus_err),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [7:0]  len;
        logic        ill;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec   = 0;
    int   n_miss  = 0;
    int   ack_delay = 0;
    int   ack_cnt   = 0;
    int   mon_len   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [2:0] st, input int len, input logic ill, input int cnt);
        exp_t e;
        e.st  = st;
        e.len = 8'(len);
        e.ill = ill;
        e.cnt = 16'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic timed_out(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: wait expired, state %0b halted %0b count %0d", name, state, halted, instr_count);
    endtask

    task automatic wait_count(input int target, input int budget, input string name);
        int i = 0;
        while (instr_count != 16'(target) && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (instr_count != 16'(target)) timed_out(name);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i = 0;
        while (!(state == 3'b000 && halted == 1'b0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (!(state == 3'b000 && halted == 1'b0)) timed_out(name);
    endtask

    task automatic wait_halted(input int budget, input string name);
        int i = 0;
        while (halted != 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (halted != 1'b1) timed_out(name);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int i = 0;
        while (state != s && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (state != s) timed_out(name);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},   32'(state),       32'd0);
        check({tag, "_memreq"},  32'(mem_req),     32'd0);
        check({tag, "_pdone"},   32'(phase_done),  32'd0);
        check({tag, "_irload"},  32'(ir_load),     32'd0);
        check({tag, "_halted"},  32'(halted),      32'd0);
        check({tag, "_buserr"},  32'(bus_err),     32'd0);
        check({tag, "_illegal"}, 32'(illegal),     32'd0);
        check({tag, "_count"},   32'(instr_count), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        run       = 1'b0;
        step_mode = 1'b0;
        step_req  = 1'b0;
        clear     = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Memory model: acknowledges each request after ack_delay waiting cycles.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mem_req) begin
                mem_ack = 1'b0;
                ack_cnt = 0;
            end else if (ack_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                ack_cnt = 0;
            end else begin
                mem_ack = 1'b0;
                ack_cnt++;
            end
        end
    end

    // Monitor: measures phase length and compares every completed phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n || state == 3'b000) begin
                mon_len = 0;
            end else begin
                mon_len++;
                if (phase_done) begin
                    if (exp_q.size() == 0) begin
                        timed_out("unexpected_phase");
                    end else begin
                        e = exp_q.pop_front();
                        check("phase_state", 32'(state),       32'(e.st));
                        check("phase_len",   32'(mon_len),     32'(e.len));
                        check("illegal",     32'(illegal),     32'(e.ill));
                        check("ir_load",     32'(ir_load),     32'(e.st == 3'b001));
                        check("phase_count", 32'(instr_count), 32'(e.cnt));
                    end
                    mon_len = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, state %0b", state);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        clear = 1'b0; inst = 4'b0000;

        // LDA with one wait cycle per access: 2+2+1 cycles, no bubble between instructions
        do_reset();
        inst = 4'b0000; ack_delay = 1;
        for (int i = 0; i < 2; i++) begin
            push(3'b001, 2, 1'b0, i);
            push(3'b010, 2, 1'b0, i);
            push(3'b100, 1, 1'b0, i);
        end
        run = 1'b1;
        wait_count(1, 40, "lda_first_retire");
        check("lda_no_bubble", 32'(state), 32'b001);
        run = 1'b0;
        wait_idle(40, "lda_idle");
        check("lda_count", 32'(instr_count), 32'd2);
        check("lda_drained", 32'(exp_q.size()), 32'd0);

        // JMP zero-wait: 2 cycles per instruction, ten instructions
        do_reset();
        inst = 4'b0100; ack_delay = 0;
        for (int i = 0; i < 10; i++) begin
            push(3'b001, 1, 1'b0, i);
            push(3'b010, 1, 1'b0, i);
        end
        run = 1'b1;
        wait_count(9, 60, "jmp_nine");
        run = 1'b0;
        wait_idle(20, "jmp_idle");
        check("jmp_count", 32'(instr_count), 32'd10);
        check("jmp_drained", 32'(exp_q.size()), 32'd0);

        // single step of STA, with a stray step_req mid-instruction
        do_reset();
        step_mode = 1'b1; inst = 4'b0001; ack_delay = 1;
        for (int i = 0; i < 3; i++) begin
            push(3'b001, 2, 1'b0, i);
            push(3'b010, 2, 1'b0, i);
            step_req = 1'b1;
            @(negedge clk);
            step_req = 1'b0;
            @(negedge clk);
            step_req = 1'b1;
            @(negedge clk);
            step_req = 1'b0;
            wait_idle(20, "step_idle");
            check("step_count", 32'(instr_count), 32'(i + 1));
        end
        repeat (3) @(negedge clk);
        check("step_hold_state", 32'(state), 32'd0);
        check("step_hold_count", 32'(instr_count), 32'd3);
        check("step_drained", 32'(exp_q.size()), 32'd0);

        // STP halts without retiring; clear returns to IDLE and run restarts
        do_reset();
        inst = 4'b0111; ack_delay = 0;
        push(3'b001, 1, 1'b0, 0);
        push(3'b010, 1, 1'b0, 0);
        run = 1'b1;
        wait_halted(20, "stp_halt");
        check("stp_state", 32'(state), 32'd0);
        check("stp_memreq", 32'(mem_req), 32'd0);
        check("stp_count", 32'(instr_count), 32'd0);
        check("stp_buserr", 32'(bus_err), 32'd0);
        repeat (3) @(negedge clk);
        check("stp_run_ignored", 32'(halted), 32'd1);
        run = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("stp_clear_halted", 32'(halted), 32'd0);
        check("stp_clear_state", 32'(state), 32'd0);
        inst = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            push(3'b001, 1, 1'b0, i);
            push(3'b010, 1, 1'b0, i);
        end
        run = 1'b1;
        wait_count(1, 20, "restart_first");
        run = 1'b0;
        wait_idle(20, "restart_idle");
        check("restart_count", 32'(instr_count), 32'd2);
        check("stp_drained", 32'(exp_q.size()), 32'd0);

        // bus timeout: 15 unacknowledged cycles halt, ack on cycle 15 does not
        do_reset();
        inst = 4'b0100; ack_delay = 1000;
        run = 1'b1;
        repeat (15) @(negedge clk);
        check("to_cycle15_halted", 32'(halted), 32'd0);
        check("to_cycle15_memreq", 32'(mem_req), 32'd1);
        @(negedge clk);
        check("to_halted", 32'(halted), 32'd1);
        check("to_buserr", 32'(bus_err), 32'd1);
        check("to_memreq", 32'(mem_req), 32'd0);
        check("to_count", 32'(instr_count), 32'd0);
        run = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("to_clear_buserr", 32'(bus_err), 32'd0);
        check("to_clear_halted", 32'(halted), 32'd0);
        ack_delay = 14;
        push(3'b001, 15, 1'b0, 0);
        push(3'b010, 1, 1'b0, 0);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_idle(40, "late_ack_idle");
        check("late_ack_buserr", 32'(bus_err), 32'd0);
        check("late_ack_count", 32'(instr_count), 32'd1);
        check("late_ack_drained", 32'(exp_q.size()), 32'd0);

        // asynchronous reset during an EXEC1 wait, then an illegal opcode
        do_reset();
        inst = 4'b0000; ack_delay = 3;
        push(3'b001, 4, 1'b0, 0);
        run = 1'b1;
        wait_state(3'b010, 20, "exec1_reach");
        #1;
        check("exec1_wait_memreq", 32'(mem_req), 32'd1);
        check("exec1_wait_pdone", 32'(phase_done), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        check("async_rst_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        inst = 4'b1010; ack_delay = 0;
        push(3'b001, 1, 1'b0, 0);
        push(3'b010, 1, 1'b1, 0);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_idle(20, "illegal_idle");
        check("illegal_count", 32'(instr_count), 32'd1);
        check("illegal_pulse_gone", 32'(illegal), 32'd0);
        check("illegal_drained", 32'(exp_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Phase sequencer for the accumulator CPU. It generates the one-hot fetch/exec1/exec2 phase vector that the instruction decoder consumes.
- Stretches each phase across the memory request/acknowledge handshake.
- Implements run, single-step, STP halt and bus-timeout halt.
- Sits between the top-level control inputs, the shared instruction/data memory handshake and the decoder/IR/PC registers.

Parameters:
- WAIT_MAX, 15, maximum cycles mem_req may stay unacknowledged before a bus error halt (1..255).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = execute continuously.
- step_mode  in  1  level; 1 = stop in IDLE after each instruction.
- step_req  in  1  single-cycle pulse; start one instruction from IDLE when step_mode=1.
- clear  in  1  single-cycle pulse; leave HALT for IDLE, clears bus_err.
- inst  in  4  IR opcode, valid from the cycle after ir_load.
- mem_ack  in  1  memory completes the current access this cycle.
- state  out  3  one-hot phase: [0] fetch, [1] exec1, [2] exec2; 000 in IDLE/HALT.
- phase_done  out  1  strobe on the last cycle of a phase; datapath registers enable on it.
- ir_load  out  1  = state[0] & phase_done.
- mem_req  out  1  memory access request.
- halted  out  1  1 in HALT.
- bus_err  out  1  sticky; set on timeout.
- illegal  out  1  one-cycle pulse when exec1 completes with opcode 1001–1011.
- instr_count  out  CNT_W  retired instructions, saturating.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. state=000, phase_done=0, mem_req=0, halted=0, bus_err=0, illegal=0, instr_count=0, wait counter=0.
- States: IDLE, FETCH, EXEC1, EXEC2, HALT.
- Opcode classes:
  - MEM = 0000 LDA, 0001 STA, 0010 ADD, 0011 SUB.
  - 2-phase = LDA, ADD, SUB, and ARM = 11xx.
  - STP = 0111.
  - All other opcodes are 1-phase.
- IDLE:
  - run=1 & step_mode=0 → FETCH next cycle.
  - step_mode=1 & step_req=1 → FETCH.
  - Otherwise hold.
- FETCH:
  - mem_req=1.
  - phase_done = mem_ack. On ack: ir_load, → EXEC1.
- EXEC1:
  - MEM opcodes: mem_req=1, phase_done = mem_ack.
  - Non-MEM opcodes: phase_done=1 in the first cycle.
  - On phase_done:
    - STP → HALT.
    - 2-phase opcode → EXEC2.
    - Otherwise retire.
- EXEC2:
  - phase_done=1 in the first cycle, no memory access, then retire.
- Retire: instr_count increments (holds at all-ones). Next state:
  - step_mode=1 → IDLE.
  - run=0 → IDLE.
  - Otherwise → FETCH with no bubble cycle.
  - STP does not retire-count.
- HALT:
  - halted=1, mem_req=0.
  - clear → IDLE, clears bus_err. run is ignored until clear.
- Phase vector:
  - state is held constant for the whole phase, including wait cycles.
  - The decoder's combinational outputs stay stable during waits. Register-writing consumers qualify with phase_done.
- Timeout:
  - The wait counter counts cycles with mem_req=1 & mem_ack=0 and resets each phase.
  - When it reaches WAIT_MAX with no ack: → HALT, bus_err=1. The pending access is abandoned and nothing retires.
  - An ack in the same cycle the counter reaches WAIT_MAX wins; no error.
- Precedence and boundary cases:
  - step_req while not in IDLE is ignored.
  - step_mode or run changes mid-instruction take effect only at retire.
  - clear outside HALT is ignored.
  - mem_ack while mem_req=0 is ignored.
- Reset mid-operation: immediate return to the reset values. mem_req drops asynchronously.

Test Plan:
- Reset, run=1, inst=0000 (LDA), mem_ack one cycle after each request → phases FETCH(2 cycles), EXEC1(2), EXEC2(1). instr_count=1 after 5 cycles; next FETCH starts immediately.
- inst=0100 (JMP), zero-wait mem_ack=1 → FETCH 1 cycle, EXEC1 1 cycle, 2 cycles per instruction. After 10 instructions instr_count=10; EXEC2 never seen.
- step_mode=1, run=0, three step_req pulses with inst=0001 → exactly 3 instructions retire, IDLE after each. A step_req issued mid-instruction is ignored.
- inst=0111 (STP) → HALT after EXEC1, halted=1, instr_count unchanged. clear → IDLE, then run=1 restarts FETCH.
- mem_ack held 0 with WAIT_MAX=15 → HALT on the 15th unacknowledged cycle, bus_err=1. A repeat run with the ack arriving on cycle 15 → no error.
- rst_n pulsed low during EXEC1 wait → all outputs return to reset values without waiting for a clock edge. inst=1010 → illegal pulse, retires as a 1-phase instruction.
